datapath_ctrl: RTL and testbench

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/datapath_ctrl_pkg.sv | 93 +++++++++
 rtl/datapath_ctrl_if.sv | 34 +++
 rtl/datapath_ctrl_instr_dec.sv | 26 ++
 rtl/datapath_ctrl.sv | 100 ++++++++++
 tb/tb_datapath_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the datapath controller.
// Optional feature macro: DATAPATH_CTRL_ILLEGAL_EN (illegal flag + HALT state).
package ctrl_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned NSEL_W  = 3;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned SHIFT_W = 2;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
`ifdef DATAPATH_CTRL_ILLEGAL_EN
    ,
    S_HALT      = 3'd7
`endif
  } state_t;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
  localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALUOP_W-1:0] ALU_MVN = 2'b11;

  localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
  localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b001;
  localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b100;

  // Control bundle presented to the datapath each cycle
  typedef struct packed {
    logic               w;
    logic [NSEL_W-1:0]  nsel;
    logic               vsel;
    logic               write;
    logic               loada;
    logic               loadb;
    logic               loadc;
    logic               loads;
    logic               asel;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  // Moore output decode for a given state and the instruction held in IR
  function automatic ctrl_t ctrl_outputs(input state_t st,
                                         input logic [OPC_W-1:0] opcode,
                                         input logic [OP_W-1:0] op);
    ctrl_t o;
    o = '0;
    case (st)
      S_WAIT: o.w = 1'b1;
      S_GET_A: begin
        o.nsel  = NSEL_RN;
        o.loada = 1'b1;
      end
      S_GET_B: begin
        o.nsel  = NSEL_RM;
        o.loadb = 1'b1;
      end
      S_EXEC: begin
        o.loadc = 1'b1;
        o.aluop = (opcode == OPC_ALU) ? ALUOP_W'(op) : ALU_ADD;
        o.asel  = (opcode == OPC_MOV);
        o.loads = (opcode == OPC_ALU) && (op == ALU_SUB);
      end
      S_WRITE_REG: begin
        o.nsel  = NSEL_RD;
        o.write = 1'b1;
      end
      S_WRITE_IMM: begin
        o.nsel  = NSEL_RN;
        o.vsel  = 1'b1;
        o.write = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Handshake/control bus between the instruction source and the controller.
interface datapath_ctrl_if;
  import ctrl_pkg::*;

  logic               s;
  logic               load;
  logic [WIDTH-1:0]   in;
  logic               w;
  logic               illegal;
  logic [NSEL_W-1:0]  nsel;
  logic               vsel;
  logic               write;
  logic               loada;
  logic               loadb;
  logic               loadc;
  logic               loads;
  logic               asel;
  logic [ALUOP_W-1:0] ALUop;
  logic [SHIFT_W-1:0] shift;
  logic [WIDTH-1:0]   sximm8;

  modport master (
    output s, load, in,
    input  w, illegal, nsel, vsel, write, loada, loadb, loadc, loads, asel,
           ALUop, shift, sximm8
  );

  modport slave (
    input  s, load, in,
    output w, illegal, nsel, vsel, write, loada, loadb, loadc, loads, asel,
           ALUop, shift, sximm8
  );

endinterface

// File: rtl/datapath_ctrl_instr_dec.sv
// Combinational instruction field extraction, immediate sign extension and legality.
module instr_dec
  import ctrl_pkg::*;
(
  input  logic [WIDTH-1:0]   ir,
  output logic [OPC_W-1:0]   opcode,
  output logic [OP_W-1:0]    op,
  output logic [SHIFT_W-1:0] shift,
  output logic [WIDTH-1:0]   sximm8,
  output logic               legal
);

  // Rn is consumed by the register file address mux, not by the controller
  logic unused_rn;
  assign unused_rn = ^ir[10:8];

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign shift  = ir[4:3];
  assign sximm8 = {{(WIDTH - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  // Only MOV imm/reg and the four ALU operations are defined
  assign legal = ((opcode == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)))
               || (opcode == OPC_ALU);

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle datapath controller: holds IR, sequences register-file and ALU strobes.
// Optional feature macro: DATAPATH_CTRL_ILLEGAL_EN (sticky illegal flag and HALT state).
module datapath_ctrl
  import ctrl_pkg::*;
(
  input logic             clk,
  input logic             reset,
  datapath_ctrl_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   ir;
  ctrl_t              ctrl;
  logic [OPC_W-1:0]   opcode;
  logic [OP_W-1:0]    op;
  logic               legal;

  instr_dec u_instr_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .shift  (bus.shift),
    .sximm8 (bus.sximm8),
    .legal  (legal)
  );

  // Next-state selection; s is only honoured in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: if (bus.s) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!legal) begin
`ifdef DATAPATH_CTRL_ILLEGAL_EN
          state_nxt = S_HALT;
`else
          state_nxt = S_WAIT;
`endif
        end else if ((opcode == OPC_MOV) && (op == OP_MOV_IMM)) begin
          state_nxt = S_WRITE_IMM;
        end else if ((opcode == OPC_MOV) || (op == ALU_MVN)) begin
          state_nxt = S_GET_B;
        end else begin
          state_nxt = S_GET_A;
        end
      end
      S_GET_A: state_nxt = S_GET_B;
      S_GET_B: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = ((opcode == OPC_ALU) && (op == ALU_SUB)) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG, S_WRITE_IMM: state_nxt = S_WAIT;
`ifdef DATAPATH_CTRL_ILLEGAL_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_WAIT;
    endcase
  end

  // State, IR and registered Moore outputs (outputs pre-decoded for the next state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
      ctrl  <= ctrl_outputs(S_WAIT, '0, '0);
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_outputs(state_nxt, opcode, op);
      if ((state == S_WAIT) && bus.load) ir <= bus.in;
    end
  end

`ifdef DATAPATH_CTRL_ILLEGAL_EN
  logic illegal_q;

  // Sticky flag raised when an undefined instruction reaches decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if ((state == S_DECODE) && !legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.w     = ctrl.w;
  assign bus.nsel  = ctrl.nsel;
  assign bus.vsel  = ctrl.vsel;
  assign bus.write = ctrl.write;
  assign bus.loada = ctrl.loada;
  assign bus.loadb = ctrl.loadb;
  assign bus.loadc = ctrl.loadc;
  assign bus.loads = ctrl.loads;
  assign bus.asel  = ctrl.asel;
  assign bus.ALUop = ctrl.aluop;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: expected per-cycle control traces are queued
// by the stimulus side and compared by an independent negedge monitor.
module tb_datapath_ctrl;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic [2:0]  nsel;
    logic        vsel;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  datapath_ctrl_if bus();

  datapath_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  obs_t        sbq[$];
  logic [15:0] model_ir;
  logic        model_illegal;
  bit          mon_en;
  int          n_checks;
  int          n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.w = bus.w;         o.illegal = bus.illegal; o.nsel = bus.nsel;
    o.vsel = bus.vsel;   o.write = bus.write;     o.loada = bus.loada;
    o.loadb = bus.loadb; o.loadc = bus.loadc;     o.loads = bus.loads;
    o.asel = bus.asel;   o.aluop = bus.ALUop;     o.shift = bus.shift;
    o.sximm8 = bus.sximm8;
    return o;
  endfunction

  // Idle controller view given the instruction the model believes is in IR
  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.w       = 1'b1;
    o.illegal = model_illegal;
    o.shift   = model_ir[4:3];
    o.sximm8  = 16'($signed(model_ir[7:0]));
    return o;
  endfunction

  // Datapath step list for an instruction: A read Rn, B read Rm, C execute,
  // W write Rd from C, I write Rn from immediate. Empty means undefined.
  function automatic string steps_of(input logic [15:0] word);
    logic [2:0] opc;
    logic [1:0] op;
    opc = word[15:13];
    op  = word[12:11];
    if (opc == 3'b110 && op == 2'b10) return "I";
    if (opc == 3'b110 && op == 2'b00) return "BCW";
    if (opc == 3'b101 && op == 2'b01) return "ABC";
    if (opc == 3'b101 && op == 2'b11) return "BCW";
    if (opc == 3'b101) return "ABCW";
    return "";
  endfunction

  // Queue the full expected trace (decode, steps, return to idle); returns busy cycles
  function automatic int push_trace(input logic [15:0] word);
    string steps;
    obs_t  base;
    obs_t  o;
    steps  = steps_of(word);
    base   = idle_obs();
    base.w = 1'b0;
    sbq.push_back(base);
    for (int i = 0; i < steps.len(); i++) begin
      o = base;
      case (steps[i])
        "A": begin o.nsel = 3'b001; o.loada = 1'b1; end
        "B": begin o.nsel = 3'b100; o.loadb = 1'b1; end
        "C": begin
          o.loadc = 1'b1;
          o.aluop = (word[15:13] == 3'b101) ? word[12:11] : 2'b00;
          o.asel  = (word[15:13] == 3'b110);
          o.loads = (word[15:11] == 5'b10101);
        end
        "W": begin o.nsel = 3'b010; o.write = 1'b1; end
        "I": begin o.nsel = 3'b001; o.vsel = 1'b1; o.write = 1'b1; end
        default: o = base;
      endcase
      sbq.push_back(o);
    end
    sbq.push_back(idle_obs());
    return steps.len() + 1;
  endfunction

  // Monitor: compare every cycle against the next queued expectation or idle
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (mon_en && !reset) begin
      a = sample();
      if (sbq.size() > 0) e = sbq.pop_front();
      else e = idle_obs();
      check("cycle", 64'(a), 64'(e));
      check("strobe_onehot",
            64'($countones({a.write, a.loada, a.loadb, a.loadc}) <= 1), 64'd1);
    end
  end

  // Start an instruction, then drive junk on s/load/in while the controller is busy
  task automatic issue(input logic [15:0] word, input bit with_load);
    int n;
    @(negedge clk);
    bus.s = 1'b1; bus.load = with_load; bus.in = word;
    @(posedge clk);
    if (with_load) model_ir = word;
    n = push_trace(model_ir);
    repeat (n) begin
      @(negedge clk);
      bus.s = 1'($urandom); bus.load = 1'($urandom); bus.in = 16'($urandom);
    end
  endtask

  task automatic idle_cycle(input bit ld, input logic [15:0] word);
    @(negedge clk);
    bus.s = 1'b0; bus.load = ld; bus.in = word;
    @(posedge clk);
    if (ld) model_ir = word;
  endtask

  function automatic logic [15:0] rand_instr(input bit allow_illegal);
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, allow_illegal ? 6 : 5))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:11] = 5'b10100;
      3: r[15:11] = 5'b10101;
      4: r[15:11] = 5'b10110;
      5: r[15:11] = 5'b10111;
      default: r[15:13] = 3'($urandom_range(0, 4));
    endcase
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit allow_ill;
    bit ld;
    reset = 1'b1;
    bus.s = 1'b0; bus.load = 1'b0; bus.in = '0;
    model_ir = '0; model_illegal = 1'b0; mon_en = 1'b0;
    n_checks = 0; n_pass = 0;
`ifdef DATAPATH_CTRL_ILLEGAL_EN
    allow_ill = 1'b0;
`else
    allow_ill = 1'b1;
`endif

    repeat (2) @(negedge clk);
    check("reset_state", 64'(sample()), 64'(idle_obs()));
    reset  = 1'b0;
    mon_en = 1'b1;

    issue(16'hD0FB, 1'b1);
    issue(16'hA148, 1'b1);
    issue(16'hA900, 1'b1);
    issue(16'hB861, 1'b1);
    if (allow_ill) issue(16'hE000, 1'b1);
    idle_cycle(1'b1, 16'hC01A);
    issue(16'h0000, 1'b0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom), 16'($urandom));
      ld = 1'($urandom) || (!allow_ill && steps_of(model_ir).len() == 0);
      issue(rand_instr(allow_ill), ld);
    end
    idle_cycle(1'b0, 16'h0000);
    for (int t = 0; t < 50 && sbq.size() > 0; t++) @(negedge clk);
    check("drain", 64'(sbq.size()), 64'd0);
    @(negedge clk);
    mon_en = 1'b0;

    // Asynchronous reset while ADD is in GET_B
    bus.s = 1'b1; bus.load = 1'b1; bus.in = 16'hA148;
    @(posedge clk);
    @(negedge clk);
    bus.s = 1'b0; bus.load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("getb_loadb", 64'(bus.loadb), 64'd1);
    check("getb_nsel", 64'(bus.nsel), 64'd4);
    reset = 1'b1;
    #1;
    check("rst_async_w", 64'(bus.w), 64'd1);
    check("rst_async_loadb", 64'(bus.loadb), 64'd0);
    model_ir = '0; model_illegal = 1'b0;
    check("rst_async_state", 64'(sample()), 64'(idle_obs()));
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("no_write_after_reset", 64'(bus.write), 64'd0);
      check("idle_after_reset", 64'(bus.w), 64'd1);
    end

`ifdef DATAPATH_CTRL_ILLEGAL_EN
    // Undefined opcode halts with the sticky flag until reset
    @(negedge clk);
    bus.s = 1'b1; bus.load = 1'b1; bus.in = 16'hE000;
    @(posedge clk);
    model_ir = 16'hE000;
    model_illegal = 1'b1;
    repeat (21) @(negedge clk);
    begin
      obs_t h;
      h   = idle_obs();
      h.w = 1'b0;
      for (int i = 0; i < 20; i++) begin
        check("halt_hold", 64'(sample()), 64'(h));
        bus.s = 1'($urandom); bus.load = 1'($urandom); bus.in = 16'($urandom);
        @(negedge clk);
      end
    end
    reset = 1'b1;
    #1;
    model_ir = '0; model_illegal = 1'b0;
    check("halt_reset", 64'(sample()), 64'(idle_obs()));
    bus.s = 1'b0; bus.load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
